// File: rtl/dff_reg_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dff_reg_arbiter_if
// Description : Bundle of request/write/grant signals between N requesters
//               and the shared-register arbiter.
//               master : requesting side (drives req, we, d_in)
//               slave  : arbiter side   (drives gnt, owner, q, q_valid,
//                                        preempt)
// Ports       : req[N], we[N], d_in[N*WIDTH] (slice i = d_in[i*WIDTH +: WIDTH]),
//               gnt[N] one-hot grant, owner[clog2(N)], q[WIDTH], q_valid,
//               preempt (forced-release pulse)
// Revision    : 1.0 - initial release
// ============================================================================
interface dff_reg_arbiter_if #(
    parameter int N     = 4,
    parameter int WIDTH = 8
);
    localparam int c_ow = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]       req;
    logic [N-1:0]       we;
    logic [N*WIDTH-1:0] d_in;
    logic [N-1:0]       gnt;
    logic [c_ow-1:0]    owner;
    logic [WIDTH-1:0]   q;
    logic               q_valid;
    logic               preempt;

    modport master (
        output req, we, d_in,
        input  gnt, owner, q, q_valid, preempt
    );

    modport slave (
        input  req, we, d_in,
        output gnt, owner, q, q_valid, preempt
    );
endinterface
`default_nettype wire

// File: rtl/dff_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dff_reg_arbiter
// Description : Round-robin arbiter granting exclusive write ownership of one
//               WIDTH-bit storage register to one of N requesters. Grants are
//               registered (1-cycle latency) and a release always leaves one
//               dead cycle before the next arbitration.
// Ports       : clk  - clock, rising edge
//               rst  - synchronous active-high reset
//               bus  - dff_reg_arbiter_if.slave (req/we/d_in in;
//                      gnt/owner/q/q_valid/preempt out)
// Options     : DFF_ARB_TIMEOUT_EN - when defined, a grant held for MAX_HOLD
//               cycles is forcibly released if another requester is waiting,
//               signalled by a one-cycle preempt pulse. When undefined the
//               hold counter is absent and preempt is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module dff_reg_arbiter #(
    parameter int N        = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    dff_reg_arbiter_if.slave   bus
);
    localparam int c_ow = (N > 1) ? $clog2(N) : 1;

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_grant = 1'b1;

    logic [0:0]       r_state;
    logic [N-1:0]     r_gnt;
    logic [c_ow-1:0]  r_owner;
    logic [c_ow-1:0]  r_ptr;
    logic [WIDTH-1:0] r_q;
    logic             r_q_valid;

    logic [0:0]       w_state_nxt;
    logic [N-1:0]     w_gnt_nxt;
    logic [c_ow-1:0]  w_owner_nxt;
    logic [c_ow-1:0]  w_ptr_nxt;
    logic             w_grant_start;

    logic             w_found;
    logic [c_ow-1:0]  w_winner;
    logic [c_ow-1:0]  w_scan_idx;
    logic [c_ow-1:0]  w_owner_inc;
    logic             w_owner_req;
    logic             w_wr_en;
    logic [WIDTH-1:0] w_wr_data;

`ifdef DFF_ARB_TIMEOUT_EN
    localparam int                  c_hold_w   = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [c_hold_w-1:0] c_hold_max = c_hold_w'(MAX_HOLD - 1);

    logic [c_hold_w-1:0] r_hold;
    logic                r_preempt;
    logic                w_preempt_nxt;
    logic                w_others;
    logic [N-1:0]        w_owner_mask;
`endif

    // ------------------------------------------------------------------
    // Round-robin search: first set req bit scanning ptr, ptr+1, ... mod N
    // ------------------------------------------------------------------
    always_comb begin
        w_found    = 1'b0;
        w_winner   = '0;
        w_scan_idx = r_ptr;
        for (int k = 0; k < N; k++) begin
            if (!w_found && bus.req[w_scan_idx]) begin
                w_found  = 1'b1;
                w_winner = w_scan_idx;
            end
            w_scan_idx = (w_scan_idx == c_ow'(N - 1)) ? '0 : w_scan_idx + c_ow'(1);
        end
    end

    assign w_owner_inc = (r_owner == c_ow'(N - 1)) ? '0 : r_owner + c_ow'(1);
    assign w_owner_req = bus.req[r_owner];

    // Owner's data slice; only the granted slice can ever reach the register
    always_comb begin
        w_wr_data = '0;
        for (int i = 0; i < N; i++) begin
            if (r_owner == c_ow'(i)) begin
                w_wr_data = bus.d_in[i*WIDTH +: WIDTH];
            end
        end
    end

    // A write needs grant, a still-high request and WE from the same requester,
    // so a WE on the release cycle is dropped.
    assign w_wr_en = r_gnt[r_owner] & w_owner_req & bus.we[r_owner];

`ifdef DFF_ARB_TIMEOUT_EN
    always_comb begin
        w_owner_mask          = '0;
        w_owner_mask[r_owner] = 1'b1;
    end
    assign w_others = |(bus.req & ~w_owner_mask);
`endif

    // ------------------------------------------------------------------
    // FSM next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_owner_nxt   = r_owner;
        w_ptr_nxt     = r_ptr;
        w_grant_start = 1'b0;
`ifdef DFF_ARB_TIMEOUT_EN
        w_preempt_nxt = 1'b0;
`endif
        case (r_state)
            c_st_idle: begin
                if (w_found) begin
                    w_state_nxt           = c_st_grant;
                    w_gnt_nxt             = '0;
                    w_gnt_nxt[w_winner]   = 1'b1;
                    w_owner_nxt           = w_winner;
                    w_grant_start         = 1'b1;
                end
            end
            c_st_grant: begin
                if (!w_owner_req) begin
                    w_state_nxt = c_st_idle;
                    w_gnt_nxt   = '0;
                    w_ptr_nxt   = w_owner_inc;
                end
`ifdef DFF_ARB_TIMEOUT_EN
                else if ((r_hold == c_hold_max) && w_others) begin
                    w_state_nxt   = c_st_idle;
                    w_gnt_nxt     = '0;
                    w_ptr_nxt     = w_owner_inc;
                    w_preempt_nxt = 1'b1;
                end
`endif
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register, grant registers and the shared storage register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_gnt     <= '0;
            r_owner   <= '0;
            r_ptr     <= '0;
            r_q       <= '0;
            r_q_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            if (w_wr_en) begin
                r_q       <= w_wr_data;
                r_q_valid <= 1'b1;
            end
        end
    end

`ifdef DFF_ARB_TIMEOUT_EN
    // Hold counter: cleared when a grant is issued, saturates at MAX_HOLD-1
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold    <= '0;
            r_preempt <= 1'b0;
        end else begin
            r_preempt <= w_preempt_nxt;
            if (w_grant_start) begin
                r_hold <= '0;
            end else if ((r_state == c_st_grant) && (r_hold != c_hold_max)) begin
                r_hold <= r_hold + c_hold_w'(1);
            end
        end
    end

    assign bus.preempt = r_preempt;
`else
    // MAX_HOLD has no effect without the timeout; both arms tie preempt low.
    if (MAX_HOLD >= 2) begin : g_no_timeout
        assign bus.preempt = 1'b0;
    end else begin : g_no_timeout_small
        assign bus.preempt = 1'b0;
    end
`endif

    assign bus.gnt     = r_gnt;
    assign bus.owner   = r_owner;
    assign bus.q       = r_q;
    assign bus.q_valid = r_q_valid;

endmodule
`default_nettype wire

// File: doc/dff_reg_arbiter.md
# dff_reg_arbiter

Round-robin arbiter that shares one WIDTH-bit D flip-flop storage register among N requesters. A requester wins exclusive write ownership through a registered REQ/GNT handshake and, while granted, loads its data slice into the register with WE. The block sits between the requesting logic and the shared register bank. It also provides the register's Q output and an ownership indication.

## Interface
- N, 4, number of requesters (2..8)
- WIDTH, 8, storage register width
- MAX_HOLD, 8, maximum grant length in cycles when DFF_ARB_TIMEOUT_EN is defined (≥2)

- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- REQ  in  N  per-requester request level
- WE  in  N  per-requester write enable
- D_IN  in  N*WIDTH  write data; slice i = D_IN[i*WIDTH +: WIDTH]
- GNT  out  N  one-hot (or zero) registered grant
- OWNER  out  clog2(N)  index of current/last grantee
- Q  out  WIDTH  shared register contents
- Q_VALID  out  1  high once Q has been written since reset
- PREEMPT  out  1  one-cycle pulse on forced release (timeout feature)

## Operation
- Reset values: GNT=0, OWNER=0, Q=0, Q_VALID=0, PREEMPT=0, FSM=IDLE, round-robin pointer PTR=0, hold counter=0.
- RST has priority over every other event, including a mid-grant write.
- FSM states:
  - IDLE: if any REQ bit is set, pick the first set bit scanning PTR, PTR+1, … mod N. Go to GRANT and set GNT/OWNER to that winner. Otherwise stay in IDLE.
  - GRANT: if REQ[OWNER]=0, go to IDLE, set GNT=0 and PTR=(OWNER+1) mod N. Otherwise stay in GRANT.
- Write: at an edge where GNT[i]=1, REQ[i]=1 and WE[i]=1, load slice i into Q and set Q_VALID=1.
- Ignored writes:
  - WE from a non-granted requester.
  - WE together with REQ low, including the release cycle.
- Q holds its value across grants and idle periods. Only RST clears it.
- OWNER keeps the last grantee while in IDLE.

## Timing
- Grant latency: REQ sampled high at edge k in IDLE gives GNT high after edge k. That is 1 cycle.
- Release: REQ low sampled at edge k drops GNT after edge k.
- Arbitration next happens at edge k+1, so there is always at least one cycle with GNT=0 between grants (the dead cycle).
- Write latency: Q reflects D_IN after the same edge that samples WE. That is 1 cycle.
- Simultaneous requests in IDLE: the lowest index at or after PTR wins. Losers keep REQ asserted and wait; no request is dropped.
- Fairness: with all N requesting continuously and releasing after each grant, grants rotate 0,1,…,N-1,0.
- PTR wraps from N-1 to 0.

## Configuration
- DFF_ARB_TIMEOUT_EN defined:
  - The hold counter clears on grant and increments each GRANT cycle, saturating at MAX_HOLD-1.
  - At an edge where the counter equals MAX_HOLD-1, REQ[OWNER]=1, and another REQ bit is set, the block forces release. It goes to IDLE, sets GNT=0, PTR=OWNER+1, and pulses PREEMPT high for one cycle.
  - A WE at that edge is still honoured.
  - If no other requester is waiting, the grant continues with the counter saturated.
- DFF_ARB_TIMEOUT_EN undefined: the hold counter is not built, the grant lasts until the owner drops REQ, and PREEMPT is tied 0.

## Test plan
- Reset: assert RST for 2 cycles with REQ=4'b1111 and WE=4'b1111 → GNT=0, Q=8'h00, Q_VALID=0, OWNER=0 throughout; arbitration starts at the first edge after RST falls.
- Single owner write: REQ[2]=1 → GNT=4'b0100 one cycle later. Then WE[2]=1 with slice 2=8'hA5 → Q=8'hA5, Q_VALID=1. Then WE[1]=1 with slice 1=8'h3C (not granted) → Q stays 8'hA5.
- Round robin: REQ=4'b1111, each owner drops REQ for one cycle after one write cycle → GNT sequence 0001, 0010, 0100, 1000, 0001, with one GNT=0 cycle between each.
- Release/write collision: owner 0 drops REQ[0] while WE[0]=1 with data 8'hFF → Q unchanged; GNT=0 next cycle.
- Reset mid-grant: while GNT=4'b0010, assert RST together with WE[1]=1 and data 8'h77 → Q=8'h00, GNT=0.
- Timeout (DFF_ARB_TIMEOUT_EN, MAX_HOLD=8): REQ[0] and REQ[3] held high → GNT[0] high for exactly 8 cycles, PREEMPT pulses once, GNT=4'b1000 two edges after the drop. With only REQ[0] high, the grant persists past 8 cycles and PREEMPT stays 0.
